// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Time-multiplexed driver for the spectrum analyzer LED bar-graph matrix.
// Accepts one bar-graph frame per valid/ready handshake into a pending
// buffer, commits it to the display buffer only at a frame boundary (no
// tearing), overlays a per-band peak-hold dot with timed decay, and scans the
// matrix one column at a time with a blanking gap before every column.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   leds_in      frame; bit b*COLUMN_HEIGHT+j is band b, row j (row 0 = bottom)
//   frame_valid  leds_in holds a new frame
//   frame_ready  block can accept a frame (registered, = !pending_full)
//   col_sel      one-hot active-high column enable (0 while blanking)
//   row_data     active-high row drive for the selected column
//   frame_done   one-cycle pulse in the first blank cycle of a new frame
module led_matrix_scanner #(
  parameter int N_BANDS          = 8,
  parameter int COLUMN_HEIGHT    = 16,
  parameter int SCAN_DIV         = 6250,
  parameter int BLANK_CYCLES     = 2,
  parameter int PEAK_HOLD_FRAMES = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_BANDS*COLUMN_HEIGHT-1:0]   leds_in,
  input  logic                               frame_valid,
  output logic                               frame_ready,
  output logic [N_BANDS-1:0]                 col_sel,
  output logic [COLUMN_HEIGHT-1:0]           row_data,
  output logic                               frame_done
);

  localparam int PW   = $clog2(COLUMN_HEIGHT + 1);
  localparam int HW   = $clog2(PEAK_HOLD_FRAMES + 1);
  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
  localparam int FW   = N_BANDS * COLUMN_HEIGHT;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [SW-1:0]             col, col_n;
  logic                      boundary;

  logic [FW-1:0]             pending, display, disp_n;
  logic                      pending_full, pending_full_n;
  logic                      xfer, commit;

  logic [PW-1:0]             peak   [N_BANDS];
  logic [PW-1:0]             peak_n [N_BANDS];
  logic [HW-1:0]             hold   [N_BANDS];
  logic [HW-1:0]             hold_n [N_BANDS];
  logic [PW-1:0]             lvl    [N_BANDS];
  logic [COLUMN_HEIGHT-1:0]  row_n;

  // Index of highest set bit + 1; tolerates non-thermometer columns.
  function automatic logic [PW-1:0] level_of(input logic [COLUMN_HEIGHT-1:0] c);
    logic [PW-1:0] l;
    l = '0;
    for (int j = 0; j < COLUMN_HEIGHT; j++)
      if (c[j]) l = PW'(j + 1);
    return l;
  endfunction

  function automatic logic [COLUMN_HEIGHT-1:0] dot_of(input logic [PW-1:0] p);
    logic [COLUMN_HEIGHT-1:0] d;
    d = '0;
    if (p != '0) d = COLUMN_HEIGHT'(1) << (p - PW'(1));
    return d;
  endfunction

  // Scan sequencer: BLANK for BLANK_CYCLES, then DRIVE for SCAN_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CW'(1);
    col_n    = col;
    boundary = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          state_n = BLANK;
          cnt_n   = '0;
          if (col == SW'(N_BANDS - 1)) begin
            col_n    = '0;
            boundary = 1'b1;
          end else begin
            col_n = col + SW'(1);
          end
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // Frame buffering. A full pending buffer holds ready low, so a transfer
  // and a commit can never land in the same cycle.
  assign xfer   = frame_valid && frame_ready;
  assign commit = boundary && pending_full;
  assign disp_n = commit ? pending : display;

  always_comb begin
    pending_full_n = pending_full;
    if (commit) pending_full_n = 1'b0;
    if (xfer)   pending_full_n = 1'b1;
  end

  // Peak hold/decay, evaluated on the freshly committed display contents.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      lvl[b]    = level_of(disp_n[b*COLUMN_HEIGHT +: COLUMN_HEIGHT]);
      peak_n[b] = peak[b];
      hold_n[b] = hold[b];
      if (boundary) begin
        if (lvl[b] >= peak[b]) begin
          peak_n[b] = lvl[b];
          hold_n[b] = HW'(PEAK_HOLD_FRAMES);
        end else if (hold[b] != '0) begin
          hold_n[b] = hold[b] - HW'(1);
        end else begin
          peak_n[b] = peak[b] - PW'(1);
        end
      end
    end
  end

  // Column image; col_n/registers are stable during DRIVE since the
  // boundary update always happens on entry to BLANK.
  always_comb begin
    row_n = display[int'(col_n)*COLUMN_HEIGHT +: COLUMN_HEIGHT] | dot_of(peak[col_n]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
      display      <= '0;
      frame_ready  <= 1'b1;
      frame_done   <= 1'b0;
      col_sel      <= '0;
      row_data     <= '0;
      for (int b = 0; b < N_BANDS; b++) begin
        peak[b] <= '0;
        hold[b] <= '0;
      end
    end else begin
      if (xfer) pending <= leds_in;
      pending_full <= pending_full_n;
      display      <= disp_n;
      frame_ready  <= !pending_full_n;
      frame_done   <= boundary;
      for (int b = 0; b < N_BANDS; b++) begin
        peak[b] <= peak_n[b];
        hold[b] <= hold_n[b];
      end
      if (state_n == DRIVE) begin
        col_sel  <= N_BANDS'(1) << col_n;
        row_data <= row_n;
      end else begin
        col_sel  <= '0;
        row_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;

  localparam int NB = 8;
  localparam int CH = 16;

  logic              clk;
  logic              rst_n;
  logic [NB*CH-1:0]  leds_in;
  logic              frame_valid;
  logic              frame_ready;
  logic [NB-1:0]     col_sel;
  logic [CH-1:0]     row_data;
  logic              frame_done;

  int total = 0;
  int bad   = 0;
  logic [CH-1:0] exp_q[$];

  led_matrix_scanner #(
    .N_BANDS(NB), .COLUMN_HEIGHT(CH), .SCAN_DIV(4),
    .BLANK_CYCLES(1), .PEAK_HOLD_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .col_sel(col_sel), .row_data(row_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [NB*CH-1:0] fr(input logic [CH-1:0] b0, b1, b2, b3,
                                          b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic push_frame(input logic [NB*CH-1:0] f);
    for (int c = 0; c < NB; c++) exp_q.push_back(f[c*CH +: CH]);
  endtask

  // Starts just after a frame_done sample, ends on the next frame_done sample.
  task automatic capture(input string tag);
    logic [CH-1:0] e;
    int n;
    for (int c = 0; c < NB; c++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (col_sel == '0 && n < 20);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk({tag, " col_sel"}, 32'(col_sel), 32'(NB'(1) << c));
      chk({tag, " row_data"}, 32'(row_data), 32'(e));
      chk({tag, " frame_done low"}, 32'(frame_done), 32'(0));
      n = 0;
      do begin @(negedge clk); n++; end while (col_sel != '0 && n < 20);
    end
    chk({tag, " frame_done"}, 32'(frame_done), 32'(1));
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    chk({tag, " wait frame_done"}, 32'(frame_done), 32'(1));
  endtask

  task automatic send(input logic [NB*CH-1:0] f, input string tag);
    chk({tag, " ready before"}, 32'(frame_ready), 32'(1));
    leds_in     = f;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    chk({tag, " ready after"}, 32'(frame_ready), 32'(0));
  endtask

  initial begin
    logic [NB*CH-1:0] fa, fb, fc, fd, zero;
    logic [CH-1:0] dec [8];
    logic [NB-1:0] ecs;
    int n;

    zero        = '0;
    leds_in     = '0;
    frame_valid = 1'b0;
    rst_n       = 1'b1;
    #2 rst_n    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst col_sel", 32'(col_sel), 32'(0));
    chk("rst row_data", 32'(row_data), 32'(0));
    chk("rst frame_done", 32'(frame_done), 32'(0));
    chk("rst frame_ready", 32'(frame_ready), 32'(1));

    // Scan sequence after release: 1 blank, 4 drive per column, wraps after 0x80
    rst_n = 1'b1;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      ecs = (((j - 1) % 5) < 4) ? (NB'(1) << (((j - 1) / 5) % 8)) : '0;
      chk("scan col_sel", 32'(col_sel), 32'(ecs));
      chk("scan row_data", 32'(row_data), 32'(0));
      chk("scan frame_done", 32'(frame_done), 32'(j == 40));
    end
    wait_fd("align");

    // Single frame
    send(fr(16'h00FF, 0, 0, 0, 0, 0, 0, 0), "single");
    push_frame(zero);
    capture("single pre");
    push_frame(fr(16'h00FF, 0, 0, 0, 0, 0, 0, 0));
    capture("single");

    // Peak hold then decay on band 0
    send(fr(16'h000F, 0, 0, 0, 0, 0, 0, 0), "peak");
    dec = '{16'h00FF, 16'h008F, 16'h008F, 16'h004F, 16'h002F, 16'h001F,
            16'h000F, 16'h000F};
    for (int k = 0; k < 8; k++) begin
      push_frame(fr(dec[k], 0, 0, 0, 0, 0, 0, 0));
      capture("peak");
    end

    // Backpressure: A accepted, B held until the cycle after the commit
    fa = fr(16'h000F, 0, 16'h0001, 0, 0, 0, 0, 0);
    fb = fr(16'h000F, 0, 16'h0007, 0, 0, 16'h00FF, 0, 0);
    send(fa, "bp A");
    leds_in     = fb;
    frame_valid = 1'b1;
    push_frame(fr(16'h000F, 0, 0, 0, 0, 0, 0, 0));
    capture("bp old");
    chk("bp ready rise", 32'(frame_ready), 32'(1));
    @(posedge clk);
    #1;
    chk("bp B taken", 32'(frame_ready), 32'(0));
    frame_valid = 1'b0;
    push_frame(fa);
    capture("bp A shown");
    push_frame(fb);
    capture("bp B shown");

    // Transfer on the boundary cycle with pending empty
    n = 0;
    do begin @(negedge clk); n++; end while (col_sel != 8'h80 && n < 60);
    chk("simul reach col7", 32'(col_sel), 32'(8'h80));
    repeat (3) @(negedge clk);
    chk("simul last drive", 32'(col_sel), 32'(8'h80));
    chk("simul ready", 32'(frame_ready), 32'(1));
    fc = fr(16'h000F, 0, 16'h0007, 16'h0001, 0, 16'h00FF, 0, 16'h0FFF);
    leds_in     = fc;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    chk("simul frame_done", 32'(frame_done), 32'(1));
    chk("simul ready low", 32'(frame_ready), 32'(0));
    push_frame(fb);
    capture("simul not yet");
    push_frame(fc);
    capture("simul shown");

    // Reset mid-DRIVE of col 3 with a pending frame
    fd = fr(0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    send(fd, "mid rst");
    n = 0;
    do begin @(negedge clk); n++; end while (col_sel != 8'h08 && n < 60);
    @(negedge clk);
    chk("mid rst pre col_sel", 32'(col_sel), 32'(8'h08));
    chk("mid rst pre row", 32'(row_data), 32'(16'h0001));
    rst_n = 1'b0;
    #1;
    chk("mid rst col_sel", 32'(col_sel), 32'(0));
    chk("mid rst row_data", 32'(row_data), 32'(0));
    chk("mid rst frame_done", 32'(frame_done), 32'(0));
    chk("mid rst frame_ready", 32'(frame_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd("post rst");
    push_frame(zero);
    capture("post rst 0");
    push_frame(zero);
    capture("post rst 1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
